// File: rtl/tdm_demux_if.sv
// Bundles the TDM receive stream and the demultiplexed channel outputs.
// The master modport drives the stream; the slave modport is the demux itself.
interface tdm_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       dout_valid;
  logic                      frame_done;
  logic                      sync_err;
  logic                      locked;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, frame_done, sync_err, locked
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer with HUNT/LOCKED slot alignment and error recovery.
// Define TDM_DEMUX_FRAME_BUF_EN to stage slots and publish whole frames at once.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);
  localparam int SW = $clog2(CHANNELS);
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [WIDTH-1:0]    dout_q [CHANNELS];
  logic [CHANNELS-1:0] dout_valid_q;
  logic                frame_done_q;
  logic                sync_err_q;
`ifdef TDM_DEMUX_FRAME_BUF_EN
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
`endif

  logic          acc;
  logic [SW-1:0] acc_slot;
  logic          err;

  // Decide whether this beat is accepted, into which slot, and the alignment outcome.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    acc      = 1'b0;
    acc_slot = '0;
    err      = 1'b0;
    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        if (bus.frame_sync) begin
          acc     = 1'b1;
          state_d = LOCKED;
          slot_d  = ONE;
        end
      end else if (bus.frame_sync) begin
        acc    = 1'b1;
        err    = (slot_q != '0);
        slot_d = ONE;
      end else if (slot_q == '0) begin
        err     = 1'b1;
        state_d = HUNT;
        slot_d  = '0;
      end else begin
        acc      = 1'b1;
        acc_slot = slot_q;
        slot_d   = (slot_q == LAST) ? '0 : slot_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      dout_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        dout_q[k] <= '0;
`ifdef TDM_DEMUX_FRAME_BUF_EN
        shadow_q[k] <= '0;
`endif
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      sync_err_q   <= err;
      frame_done_q <= acc && (acc_slot == LAST);
      dout_valid_q <= '0;
`ifdef TDM_DEMUX_FRAME_BUF_EN
      // Aborted frames are simply overwritten in the shadow bank before reaching dout.
      if (acc) begin
        if (acc_slot == LAST) begin
          for (int k = 0; k < CHANNELS; k++) dout_q[k] <= shadow_q[k];
          dout_q[LAST] <= bus.din;
          dout_valid_q <= '1;
        end else begin
          shadow_q[acc_slot] <= bus.din;
        end
      end
`else
      if (acc) begin
        dout_q[acc_slot]       <= bus.din;
        dout_valid_q[acc_slot] <= 1'b1;
      end
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_pack
      assign bus.dout[gi*WIDTH +: WIDTH] = dout_q[gi];
    end
  endgenerate

  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state_q == LOCKED);
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer that receives a slot-interleaved word stream and distributes each slot to its own channel register. It sits at the receive end of a TDM link whose transmit end selects channels through a mux tree into one shared data path. A `frame_sync` marker aligns the block to slot 0. The block detects alignment errors and recovers from them.

## Interface
- `WIDTH`, default 8: bits per data word / slot.
- `CHANNELS`, default 4: slots per frame; must be ≥ 2. Slot counter width is `$clog2(CHANNELS)`.
- Ports:
  - `clk` input 1: single clock; all logic on the rising edge.
  - `rst` input 1: asynchronous, active-high reset.
  - `din` input WIDTH: slot data word.
  - `din_valid` input 1: `din` carries a slot this cycle.
  - `frame_sync` input 1: qualified by `din_valid`; marks the current beat as slot 0.
  - `dout` output CHANNELS*WIDTH: channel k occupies bits `[k*WIDTH +: WIDTH]`.
  - `dout_valid` output CHANNELS: per-channel one-cycle update strobe.
  - `frame_done` output 1: one-cycle pulse when slot CHANNELS-1 has been delivered.
  - `sync_err` output 1: one-cycle pulse on an alignment error.
  - `locked` output 1: high in the LOCKED state.

## Operation
- FSM states: HUNT (reset state) and LOCKED. `slot` counter runs 0..CHANNELS-1.
- In HUNT:
  - Beats without `frame_sync` are discarded.
  - A beat with `din_valid & frame_sync` is accepted as slot 0. The FSM goes to LOCKED and `slot` becomes 1.
- In LOCKED, every `din_valid` beat is accepted as slot `slot`:
  - `slot` increments on each accepted beat.
  - It wraps from CHANNELS-1 to 0.
- Alignment checks apply to every beat accepted in LOCKED:
  - If `frame_sync` is set while `slot` ≠ 0: pulse `sync_err`. The beat is still accepted, but as slot 0 (resync), and `slot` becomes 1. The block stays LOCKED.
  - If `slot` = 0 and `frame_sync` is low: pulse `sync_err`, discard the beat, go to HUNT, and clear `slot` to 0.
- `din_valid` low: no state change. Gaps of any length within a frame are legal.
- Accepting slot k writes `din` into channel register k and pulses `dout_valid[k]`.
- Non-accepted channels hold their values.
- `frame_done` pulses alongside the delivery of slot CHANNELS-1.
- Reset values: `dout` all zeros, `dout_valid` 0, `frame_done` 0, `sync_err` 0, `locked` 0. State is HUNT with `slot` 0.
- If reset asserts mid-frame, partial frame contents are lost and the outputs clear immediately (asynchronously).

## Timing
- Latency: a beat accepted at edge N appears on `dout` with its `dout_valid` bit high for exactly the cycle after edge N (registered outputs).
- `sync_err` and `frame_done` are registered and aligned with the corresponding `dout_valid` cycle.
- `locked` rises in the same cycle as `dout_valid[0]` of the first accepted frame.
- Throughput: one slot per cycle with `din_valid` held high. Back-to-back frames need no idle cycle.
- Reset release: the first edge after `rst` deasserts may already accept a sync beat.

## Configuration
- `TDM_DEMUX_FRAME_BUF_EN`, defined:
  - Slots are staged in a shadow register bank.
  - On acceptance of slot CHANNELS-1, the whole bank transfers to `dout` at once, and all `dout_valid` bits pulse together with `frame_done`.
  - A frame aborted by a HUNT transition or a resync never reaches `dout`; the staged data is discarded.
- `TDM_DEMUX_FRAME_BUF_EN`, not defined: per-slot update as described in Operation. No shadow bank.

## Test plan
- **Basic frame:** reset; send sync + 0xA0, then 0xA1, 0xA2, 0xA3 on consecutive cycles.
  - Required: `dout` = {A3,A2,A1,A0}.
  - `dout_valid` strobes 0001, 0010, 0100, 1000 on consecutive cycles.
  - `frame_done` pulses with 1000; `locked` = 1.
- **HUNT discard:** send 0x11, 0x22 without sync before the first sync frame.
  - Required: `dout` stays 0, `locked` = 0, no `sync_err`.
- **Gaps:** frame with `din_valid` low for 3 cycles between slots 1 and 2.
  - Required: identical `dout` result; slots land in the correct channels.
- **Early sync:** sync asserted on the third beat (0x55).
  - Required: `sync_err` pulses, `dout_valid` = 0001, channel 0 = 0x55; the next beat writes channel 1.
- **Missing sync:** after a full frame, send 0x77 without sync.
  - Required: `sync_err` pulses, channel 0 unchanged, `locked` = 0.
  - A following sync frame relocks.
- **Async reset mid-frame:** assert `rst` between clock edges after slot 1.
  - Required: outputs zero immediately.
  - With `TDM_DEMUX_FRAME_BUF_EN`: no partial frame ever appears and `dout_valid` = 1111 only on frame completion.
